// File: rtl/uart_rx_fsm_if.sv
// Serial receive bus between the line side and the host-side buffer.
// Latency: none, this is wiring only.
// Backpressure: none; rx_valid is a one-clk pulse and the host must take it.
// Ports: baud_tick/rx_in run towards the receiver; rx_data, rx_valid,
//        parity_err, frame_err, rx_busy and break_det run back to the host.
// Modports: master = line/host side, slave = receiver.
interface uart_rx_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;
  logic                 break_det;

  modport master (
    output baud_tick, rx_in,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy, break_det
  );

  modport slave (
    input  baud_tick, rx_in,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy, break_det
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver, 16x oversampled: start, DATA_BITS LSB first, parity, stop.
// Latency: rx_valid in the clk after the stop-bit midpoint tick (+2 clk sync).
// Backpressure: none; each frame is presented once with a one-clk rx_valid.
// Ports: clk, rst (sync, active-high), bus (uart_rx_fsm_if.slave):
//        baud_tick, rx_in in; rx_data, rx_valid, parity_err, frame_err,
//        rx_busy, break_det out.
// Option: define RX_BREAK_DETECT_EN to build the break detector; otherwise
//         break_det is tied low.
module uart_rx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fsm_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    BITS_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    START_BIT  = 3'b001,
    DATA_BIT   = 3'b010,
    PARITY_BIT = 3'b011,
    STOP_BIT   = 3'b100
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 armed;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rx_meta;
  logic                 rx_s;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 rx_busy_q;
`ifdef RX_BREAK_DETECT_EN
  logic                 break_q;
`endif

  // Synchronizer resets to the idle level so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      armed        <= 1'b0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      break_q      <= 1'b0;
`endif
    end else begin
      // Pulses clear on the next clk regardless of baud_tick.
      rx_valid_q <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      break_q    <= 1'b0;
`endif
      if (bus.baud_tick) begin
        case (state)
          IDLE: begin
            // Only a high-to-low edge after seeing idle can start a frame.
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state     <= START_BIT;
              tick_cnt  <= '0;
              rx_busy_q <= 1'b1;
            end
          end
          START_BIT: begin
            if (tick_cnt == TICK_HALF) begin
              if (!rx_s) begin
                state    <= DATA_BIT;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                // Start pulse too short: treat as a glitch.
                state     <= IDLE;
                rx_busy_q <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA_BIT: begin
            if (tick_cnt == TICK_LAST) begin
              // LSB arrives first, so shifting right lands it at bit 0.
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              tick_cnt <= '0;
              if (bit_cnt == BITS_LAST) state <= PARITY_BIT;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY_BIT: begin
            if (tick_cnt == TICK_LAST) begin
              par_bit  <= rx_s;
              tick_cnt <= '0;
              state    <= STOP_BIT;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP_BIT: begin
            if (tick_cnt == TICK_LAST) begin
              rx_data_q    <= shreg;
              parity_err_q <= ((^shreg) ^ par_bit) != PARITY_ODD;
              frame_err_q  <= ~rx_s;
              rx_valid_q   <= 1'b1;
`ifdef RX_BREAK_DETECT_EN
              break_q      <= (shreg == '0) && !par_bit && !rx_s;
`endif
              // Disarm so a line stuck low cannot retrigger.
              armed        <= 1'b0;
              tick_cnt     <= '0;
              rx_busy_q    <= 1'b0;
              state        <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            tick_cnt  <= '0;
            rx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_busy    = rx_busy_q;
`ifdef RX_BREAK_DETECT_EN
  assign bus.break_det  = break_q;
`else
  assign bus.break_det  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: baud_tick every 4th clk, so one bit = 64 clk.
module tb_uart_rx_fsm;
  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] div = 2'd0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int valid_cnt = 0;
  int break_cnt = 0;
  int v0;

  uart_rx_fsm_if #(.DATA_BITS(8)) bus ();

  uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial bus.baud_tick = 1'b0;
  always @(posedge clk) begin
    div           <= div + 2'd1;
    bus.baud_tick <= (div == 2'd3);
  end

  // Pulse counters; a pulse wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (bus.rx_valid)  valid_cnt <= valid_cnt + 1;
    if (bus.break_det) break_cnt <= break_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    bus.rx_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      wait_clks(BIT_CLKS);
    end
    bus.rx_in = par;
    wait_clks(BIT_CLKS);
    bus.rx_in = stp;
    wait_clks(BIT_CLKS);
    bus.rx_in = 1'b1;
  endtask

  initial begin
    bus.rx_in = 1'b1;
    wait_clks(5);
    check("rst_data",   32'(bus.rx_data),    32'h0);
    check("rst_valid",  32'(bus.rx_valid),   32'h0);
    check("rst_perr",   32'(bus.parity_err), 32'h0);
    check("rst_ferr",   32'(bus.frame_err),  32'h0);
    check("rst_busy",   32'(bus.rx_busy),    32'h0);
    check("rst_break",  32'(bus.break_det),  32'h0);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);

    // 0xA5, even parity bit 0, good stop
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_clks(BIT_CLKS);
    check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("a5_data",      32'(bus.rx_data),    32'hA5);
    check("a5_perr",      32'(bus.parity_err), 32'h0);
    check("a5_ferr",      32'(bus.frame_err),  32'h0);
    check("a5_busy",      32'(bus.rx_busy),    32'h0);

    // 0x3C with wrong parity, then with correct parity
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_clks(BIT_CLKS);
    check("3c_bad_data",  32'(bus.rx_data),    32'h3C);
    check("3c_bad_perr",  32'(bus.parity_err), 32'h1);
    check("3c_bad_valid", 32'(valid_cnt - v0), 32'd1);
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_clks(BIT_CLKS);
    check("3c_good_perr", 32'(bus.parity_err), 32'h0);

    // 0x55 with stop bit 0, then a clean 0x55
    v0 = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_clks(BIT_CLKS);
    check("55_bad_data", 32'(bus.rx_data),   32'h55);
    check("55_bad_ferr", 32'(bus.frame_err), 32'h1);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_clks(BIT_CLKS);
    check("55_good_ferr",  32'(bus.frame_err), 32'h0);
    check("55_valid_cnt",  32'(valid_cnt - v0), 32'd2);

    // Start glitch: line low for 4 ticks only
    v0 = valid_cnt;
    bus.rx_in = 1'b0;
    wait_clks(16);
    check("glitch_busy_hi", 32'(bus.rx_busy), 32'h1);
    bus.rx_in = 1'b1;
    wait_clks(BIT_CLKS);
    check("glitch_busy_lo", 32'(bus.rx_busy),    32'h0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_data",    32'(bus.rx_data),    32'h55);

    // Reset in the middle of data bit 3 of 0xFF
    v0 = valid_cnt;
    bus.rx_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      bus.rx_in = 1'b1;
      wait_clks(BIT_CLKS);
    end
    bus.rx_in = 1'b1;
    wait_clks(32);
    check("mid_busy_before_rst", 32'(bus.rx_busy), 32'h1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.rx_busy), 32'h0);
    wait_clks(3 * BIT_CLKS);
    check("rst_mid_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Clean 0x12 after the reset
    send_frame(8'h12, 1'b0, 1'b1);
    wait_clks(BIT_CLKS);
    check("12_data",  32'(bus.rx_data),    32'h12);
    check("12_perr",  32'(bus.parity_err), 32'h0);
    check("12_ferr",  32'(bus.frame_err),  32'h0);
    check("12_valid", 32'(valid_cnt - v0), 32'd1);

    // Break: line low for 20 bit times, then back high
    v0 = valid_cnt;
    bus.rx_in = 1'b0;
    wait_clks(20 * BIT_CLKS);
    bus.rx_in = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("brk_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("brk_data",      32'(bus.rx_data),    32'h00);
    check("brk_ferr",      32'(bus.frame_err),  32'h1);
    check("brk_perr",      32'(bus.parity_err), 32'h0);
`ifdef RX_BREAK_DETECT_EN
    check("brk_det_cnt",   32'(break_cnt), 32'd1);
`else
    check("brk_det_cnt",   32'(break_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
